feat_buf_ctrl: RTL and testbench



---
 rtl/feat_buf_ctrl.sv | 141 ++++++++++++++
 tb/tb_feat_buf_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/feat_buf_ctrl.sv
// Feature buffer controller: unpacks NUM_CH-wide input beats into a word memory with a registered host read port.
// Optional init-fill of the whole memory with INIT_VALUE on start is enabled by defining FEAT_BUF_INIT_FILL_EN.
module feat_buf_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH = 16,
   parameter int DEPTH = 43328,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         done,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_W+1:0]            host_addrb,
   output logic [31:0]                  host_dout,
   output logic [ADDR_W:0]              wr_count,
   output logic                         overflow
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0] CH_ONE    = CH_W'(1);

   typedef enum logic [2:0] {IDLE, FILL, ACCEPT, DRAIN, DONE} state_t;

   state_t                       state;
   logic [CH_W-1:0]              ch_cnt;
   logic [NUM_CH*DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0]        mem [DEPTH];
   logic                         wr_en;
   logic [DATA_WIDTH-1:0]        wr_data;
   logic                         handshake;
   logic [ADDR_W-1:0]            rd_idx;
   logic                         unused_addr_lsb;

   assign handshake       = in_valid & in_ready & (state == ACCEPT);
   assign rd_idx          = host_addrb[ADDR_W+1:2];
   assign unused_addr_lsb = ^host_addrb[1:0];

   // Control FSM; wr_count doubles as the fill pointer while filling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         done     <= 1'b0;
         in_ready <= 1'b0;
         overflow <= 1'b0;
         wr_count <= '0;
         ch_cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  wr_count <= '0;
                  done     <= 1'b0;
                  overflow <= 1'b0;
`ifdef FEAT_BUF_INIT_FILL_EN
                  state    <= FILL;
`else
                  state    <= ACCEPT;
                  in_ready <= 1'b1;
`endif
               end else if (state == DONE && in_valid) begin
                  overflow <= 1'b1;
               end
            end
`ifdef FEAT_BUF_INIT_FILL_EN
            FILL: begin
               if (wr_count == LAST_ADDR) begin
                  wr_count <= '0;
                  state    <= ACCEPT;
                  in_ready <= 1'b1;
               end else begin
                  wr_count <= wr_count + CNT_ONE;
               end
            end
`endif
            ACCEPT: begin
               if (wr_count >= DEPTH_CNT) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  in_ready <= 1'b0;
               end else if (handshake) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
                  ch_cnt   <= '0;
               end
            end
            DRAIN: begin
               wr_count <= wr_count + CNT_ONE;
               ch_cnt   <= ch_cnt + CH_ONE;
               // Filling the last word ends the layer; any channels left in the beat are lost.
               if (wr_count == LAST_ADDR) begin
                  state <= DONE;
                  done  <= 1'b1;
                  if (ch_cnt != LAST_CH) overflow <= 1'b1;
               end else if (ch_cnt == LAST_CH) begin
                  state    <= ACCEPT;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_data = shreg[DATA_WIDTH-1:0];
      if (state == DRAIN && wr_count < DEPTH_CNT) wr_en = 1'b1;
`ifdef FEAT_BUF_INIT_FILL_EN
      if (state == FILL) begin
         wr_en   = 1'b1;
         wr_data = INIT_VALUE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (handshake) shreg <= in_data;
      else if (state == DRAIN) shreg <= shreg >> DATA_WIDTH;
   end

   // Memory is deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_count[ADDR_W-1:0]] <= wr_data;
   end

   // Read-first registered port; DATA_WIDTH must not exceed 32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) host_dout <= '0;
      else if ({1'b0, rd_idx} < DEPTH_CNT) host_dout <= 32'(mem[rd_idx]);
      else host_dout <= '0;
   end

endmodule

// File: tb/tb_feat_buf_ctrl.sv
// Scoreboard bench for feat_buf_ctrl (DATA_WIDTH=8, NUM_CH=4, DEPTH=10, INIT_VALUE=8'h32).
// Builds with or without FEAT_BUF_INIT_FILL_EN; expectations adapt to the fill feature.
module tb_feat_buf_ctrl;

`ifdef FEAT_BUF_INIT_FILL_EN
   localparam bit FILL_ON = 1'b1;
`else
   localparam bit FILL_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, done, in_valid, in_ready, overflow;
   logic [31:0] in_data, host_dout;
   logic [5:0]  host_addrb;
   logic [4:0]  wr_count;

   logic rd_en = 1'b0, rd_en_d = 1'b0, chk_en = 1'b0;
   int   n_chk = 0, n_fail = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t rd_q[$];
   exp_t st_q[$];

   feat_buf_ctrl #(
      .DATA_WIDTH(8), .NUM_CH(4), .DEPTH(10), .INIT_VALUE(8'h32)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .host_addrb(host_addrb), .host_dout(host_dout),
      .wr_count(wr_count), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rd_en_d <= rd_en;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Monitor: pops read results one cycle after each read and status batches on request.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] got;
      if (rd_en_d) begin
         if (rd_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_q_underflow: got read data 0x%0h with no expectation", host_dout);
         end else begin
            e = rd_q.pop_front();
            cmp(e.name, host_dout, e.val);
         end
      end
      if (chk_en) begin
         while (st_q.size() > 0) begin
            e = st_q.pop_front();
            case (e.sel)
               0: got = 32'(wr_count);
               1: got = 32'(done);
               2: got = 32'(overflow);
               3: got = 32'(in_ready);
               default: got = host_dout;
            endcase
            cmp(e.name, got, e.val);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic st(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.name = name; e.sel = sel; e.val = val;
      st_q.push_back(e);
   endtask

   task automatic check_now();
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   task automatic rd(input string name, input logic [5:0] addr, input logic [31:0] val);
      exp_t e;
      e.name = name; e.sel = 4; e.val = val;
      rd_q.push_back(e);
      host_addrb = addr;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
`ifdef FEAT_BUF_INIT_FILL_EN
      for (int i = 0; i < 10; i++) begin
         st("fill_busy", 3, 0);
         check_now();
         tick(1);
      end
      rd("fill_word9", 6'h24, 32'h0000_0032);
`endif
      st("start_ready", 3, 1); st("start_wr_count", 0, 0);
      st("start_done", 1, 0);  st("start_ovf", 2, 0);
      check_now();
   endtask

   task automatic beat(input logic [31:0] d);
      in_data  = d;
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; host_addrb = '0;
      tick(2);
      st("rst_wr_count", 0, 0); st("rst_done", 1, 0); st("rst_ovf", 2, 0);
      st("rst_in_ready", 3, 0); st("rst_dout", 4, 0);
      check_now();
      tick(1);
      rst = 1'b0;

      // Layer 1: single beat, then reads of the unpacked channels.
      do_start();
      beat(32'h4433_2211);
      for (int i = 0; i < 4; i++) begin
         st("drain_busy", 3, 0);
         check_now();
         tick(1);
      end
      st("beat1_ready", 3, 1); st("beat1_wr_count", 0, 4);
      check_now();
      rd("word0", 6'h00, 32'h11);
      rd("word1_lsb_ignored", 6'h07, 32'h22);
      rd("word2", 6'h08, 32'h33);
      rd("word3", 6'h0C, 32'h44);
      rd("idx10_zero", 6'h29, 32'h0);
      rd("idx15_zero", 6'h3C, 32'h0);

      // Second beat with a start pulse mid-drain that must be ignored.
      beat(32'h8877_6655);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      st("beat2_wr_count", 0, 8); st("beat2_ready", 3, 1); st("beat2_done", 1, 0);
      check_now();

      // Third beat overruns DEPTH: words 8,9 written, two channels dropped.
      beat(32'hCCBB_AA99);
      tick(1);
      st("beat3_mid_wr_count", 0, 9); st("beat3_mid_ovf", 2, 0); st("beat3_mid_done", 1, 0);
      check_now();
      tick(1);
      st("full_done", 1, 1); st("full_ovf", 2, 1); st("full_wr_count", 0, 10); st("full_ready", 3, 0);
      check_now();

      // in_valid while DONE: flagged, nothing written.
      in_data  = 32'hEEEE_EEEE;
      in_valid = 1'b1;
      tick(3);
      in_valid = 1'b0;
      st("done_valid_wr_count", 0, 10); st("done_valid_ovf", 2, 1); st("done_valid_done", 1, 1);
      check_now();
      rd("word7", 6'h1C, 32'h88);
      rd("word8", 6'h20, 32'h99);
      rd("word9", 6'h24, 32'hAA);

      // Layer 2: restart from DONE, read-first collision, then reset mid-drain.
      do_start();
      beat(32'hDDCC_BBAA);
      rd("read_first_word0", 6'h00, FILL_ON ? 32'h32 : 32'h11);
      tick(1);
      rst = 1'b1;
      st("midrst_wr_count", 0, 0); st("midrst_ready", 3, 0);
      st("midrst_done", 1, 0); st("midrst_ovf", 2, 0); st("midrst_dout", 4, 0);
      check_now();
      tick(1);
      rst = 1'b0;
      tick(2);
      st("idle_wr_count", 0, 0); st("idle_ready", 3, 0);
      check_now();
      rd("after_rst_word0", 6'h00, 32'hAA);
      rd("after_rst_word1", 6'h04, 32'hBB);
      rd("abandoned_word2", 6'h08, FILL_ON ? 32'h32 : 32'h33);
      rd("abandoned_word3", 6'h0C, FILL_ON ? 32'h32 : 32'h44);

      tick(2);
      cmp("pending_expectations", 32'(rd_q.size() + st_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
